present_sbox_layer_seq: RTL and testbench
=========================================

// Module: present_sbox_layer_seq
// PURPOSE
// - Sequencer for one shared, 2-share first-order masked PRESENT S-box instance (4-bit, 8 random bits/call).
// - Applies the S-box layer to a 64-bit two-share state nibble by nibble, one issue per cycle.
// - Feeds fresh randomness per issue and collects results after the S-box register latency.
// - Sits between the round-state register and the masked S-box, with a PRNG on the side.
// PARAMETERS
// - NIBBLES   16  nibbles per state; the state width is 4*NIBBLES.
// - SBOX_LAT  1   clock edges from issue to a valid result on sbox_out*.
// - RND_W     8   random bits consumed per S-box call.
// PORTS
// - clk        in   1        rising-edge clock; the only clock.
// - rst_n      in   1        asynchronous, active-low reset.
// - in_valid   in   1        state offered.
// - in_ready   out  1        state accepted while high.
// - in_sh0     in   64       share 0 of the input state.
// - in_sh1     in   64       share 1 of the input state.
// - out_valid  out  1        result held stable while high.
// - out_ready  in   1        downstream accepts the result.
// - out_sh0    out  64       share 0 of the result.
// - out_sh1    out  64       share 1 of the result.
// - rnd_valid  in   1        PRNG word available.
// - rnd_ready  out  1        PRNG word consumed on this edge when rnd_valid is also high.
// - rnd        in   RND_W    fresh randomness.
// - sbox_in0   out  4        share-0 nibble to the S-box (bit0=a .. bit3=d).
// - sbox_in1   out  4        share-1 nibble to the S-box.
// - sbox_ran   out  RND_W    randomness to the S-box; equals rnd.
// - sbox_out0  in   4        S-box share-0 result.
// - sbox_out1  in   4        S-box share-1 result.
// - abort      in   1        synchronous cancel.
// - busy       out  1        state != IDLE.
// BEHAVIOUR
// - Reset: state IDLE; issue_cnt=0; ret_cnt=0; valid pipe=0; in_ready=1; out_valid=0; rnd_ready=0; busy=0.
//   Reset also clears state registers, so out_sh0=out_sh1=0 and sbox_in*=0.
// - States:
//   - IDLE: in_ready=1. On in_valid, capture both shares and go to RUN.
//   - RUN: rnd_ready=1. An issue happens on each edge with rnd_valid=1.
//     - Drive sbox_in* = nibble issue_cnt (bits 4i+3:4i) of each share, then increment issue_cnt.
//     - After issuing nibble NIBBLES-1, go to DRAIN.
//   - DRAIN: rnd_ready=0. Wait for ret_cnt==NIBBLES, then go to DONE.
//   - DONE: out_valid=1. On out_ready, go to IDLE.
// - Issue tracking: a valid shift register of depth SBOX_LAT tags each issue.
//   - A tag leaving the shift register writes sbox_out0/1 into nibble ret_cnt of the state register, in place.
//   - ret_cnt then increments.
// - Stalls: rnd_valid=0 inserts bubbles. Bubbles carry no tag and write nothing.
//   - sbox_in* hold their last value during a bubble.
// - Randomness: each rnd word is consumed exactly once. No word is consumed outside RUN.
// - Latency with no stalls: out_valid rises NIBBLES+SBOX_LAT+1 edges after the in handshake edge (18 with defaults).
// - Outputs: out_sh* are driven directly from the state register and are valid only while out_valid=1.
// - Counters: issue_cnt and ret_cnt are ceil(log2(NIBBLES+1)) bits wide. Neither wraps; both clear on entry to RUN.
// - abort: from any state, go to IDLE on the next edge.
//   - The valid pipe and counters clear, so in-flight S-box results are discarded.
//   - rnd_ready drops in the cycle abort is high.
//   - abort has priority over in_valid and out_ready in the same cycle.
// - DONE with out_ready=1: return to IDLE. The next in handshake is possible one cycle later. There is no bypass.
// - Reset mid-operation behaves as abort, but asynchronously.
// CONFIGURATION
// - SBOX_SEQ_ZEROIZE_EN defined:
//   - State registers and sbox_in* are forced to 0 on the out handshake and on abort.
//   - sbox_in* are 0 in every non-RUN cycle.
// - SBOX_SEQ_ZEROIZE_EN undefined:
//   - State registers keep their last contents until the next capture.
//   - sbox_in* hold their last value.
// TESTING
// - The bench pairs this block with the masked S-box and a PRESENT golden model. Every check uses out_sh0^out_sh1.
// 1. Known answer: in_sh0=64'hFEDCBA9876543210, in_sh1=0, rnd_valid=1 constant.
//    -> result 64'h21748FE3DA09B65C; out_valid 18 edges after accept; exactly 16 rnd words consumed.
// 2. Random shares: random in_sh1, in_sh0 = in_sh1 ^ 64'hFEDCBA9876543210, random rnd.
//    -> same unmasked result as test 1.
// 3. Stall: rnd_valid low for 3 cycles after nibble 5 and 2 cycles during DRAIN.
//    -> result unchanged; out_valid 21 edges after accept; no rnd consumed in DRAIN.
// 4. Backpressure: out_ready=0 for 10 cycles in DONE.
//    -> out_sh* stable and in_ready=0 throughout; in_ready rises the cycle after the out handshake.
// 5. Abort: abort at issue 9, then immediately run a new state 64'h0.
//    -> busy=0 the cycle after abort; new result 64'hCCCCCCCCCCCCCCCC; no stale nibble written.
// 6. Zeroize on vs off: after the out handshake, read out_sh0/out_sh1.
//    -> with SBOX_SEQ_ZEROIZE_EN: both 0; without: both equal the last result shares.

Source files
------------

// File: rtl/present_sbox_layer_seq.sv
// present_sbox_layer_seq: streams a 2-share 64-bit state nibble-wise through one shared masked PRESENT S-box.
// Optional SBOX_SEQ_ZEROIZE_EN clears state and S-box inputs on completion/abort and outside RUN.
module present_sbox_layer_seq #(
   parameter int NIBBLES  = 16,
   parameter int SBOX_LAT = 1,
   parameter int RND_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] in_sh0,
   input  logic [4*NIBBLES-1:0] in_sh1,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] out_sh0,
   output logic [4*NIBBLES-1:0] out_sh1,
   input  logic                 rnd_valid,
   output logic                 rnd_ready,
   input  logic [RND_W-1:0]     rnd,
   output logic [3:0]           sbox_in0,
   output logic [3:0]           sbox_in1,
   output logic [RND_W-1:0]     sbox_ran,
   input  logic [3:0]           sbox_out0,
   input  logic [3:0]           sbox_out1,
   input  logic                 abort,
   output logic                 busy
);
   localparam int CW = $clog2(NIBBLES + 1);
   localparam int W  = 4 * NIBBLES;
`ifdef SBOX_SEQ_ZEROIZE_EN
   localparam bit ZEROIZE = 1'b1;
`else
   localparam bit ZEROIZE = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state;
   logic [CW-1:0]       issue_cnt, ret_cnt;
   logic [SBOX_LAT-1:0] vpipe;
   logic [W-1:0]        sh0, sh1;
   logic                issue, ret, last;
   logic [3:0]          nxt0, nxt1;

   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;
   assign rnd_ready = state == RUN && !abort;
   assign issue     = rnd_ready && rnd_valid;
   assign ret       = vpipe[SBOX_LAT-1];
   assign last      = issue_cnt == CW'(NIBBLES - 1);
   assign out_sh0   = sh0;
   assign out_sh1   = sh1;
   assign sbox_ran  = rnd;

   // sbox_in is preloaded with the nibble for the next issue so it pairs with rnd on the issue edge
   always_comb begin
      nxt0 = '0;
      nxt1 = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (issue_cnt + 1'b1 == CW'(i)) begin
            nxt0 = sh0[4*i +: 4];
            nxt1 = sh1[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         vpipe     <= '0;
         sh0       <= '0;
         sh1       <= '0;
         sbox_in0  <= '0;
         sbox_in1  <= '0;
      end else if (abort) begin
         state     <= IDLE;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         vpipe     <= '0;
         if (ZEROIZE) begin
            sh0      <= '0;
            sh1      <= '0;
            sbox_in0 <= '0;
            sbox_in1 <= '0;
         end
      end else begin
         vpipe <= SBOX_LAT'({vpipe, issue});
         if (ret) begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (ret_cnt == CW'(i)) begin
                  sh0[4*i +: 4] <= sbox_out0;
                  sh1[4*i +: 4] <= sbox_out1;
               end
            end
            ret_cnt <= ret_cnt + 1'b1;
         end
         if (issue) begin
            issue_cnt <= issue_cnt + 1'b1;
            sbox_in0  <= last ? (ZEROIZE ? 4'h0 : sbox_in0) : nxt0;
            sbox_in1  <= last ? (ZEROIZE ? 4'h0 : sbox_in1) : nxt1;
         end
         case (state)
            IDLE: if (in_valid) begin
               state     <= RUN;
               sh0       <= in_sh0;
               sh1       <= in_sh1;
               issue_cnt <= '0;
               ret_cnt   <= '0;
               sbox_in0  <= in_sh0[3:0];
               sbox_in1  <= in_sh1[3:0];
            end
            RUN:   if (issue && last) state <= DRAIN;
            DRAIN: if (ret_cnt == CW'(NIBBLES)) state <= DONE;
            DONE: if (out_ready) begin
               state <= IDLE;
               if (ZEROIZE) begin
                  sh0      <= '0;
                  sh1      <= '0;
                  sbox_in0 <= '0;
                  sbox_in1 <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_present_sbox_layer_seq.sv
// tb_present_sbox_layer_seq: scoreboard bench pairing the sequencer with a masked S-box model and PRESENT golden model.
module tb_present_sbox_layer_seq;
   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [63:0] in_sh0, in_sh1, out_sh0, out_sh1;
   logic        rnd_valid, rnd_ready, abort, busy;
   logic [7:0]  rnd, sbox_ran;
   logic [3:0]  sbox_in0, sbox_in1, sbox_out0, sbox_out1;
   int          n_chk = 0, n_pass = 0, rnd_used = 0;
   logic [63:0] sb[$];

   present_sbox_layer_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sh0(in_sh0), .in_sh1(in_sh1), .out_valid(out_valid), .out_ready(out_ready),
      .out_sh0(out_sh0), .out_sh1(out_sh1), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
      .rnd(rnd), .sbox_in0(sbox_in0), .sbox_in1(sbox_in1), .sbox_ran(sbox_ran),
      .sbox_out0(sbox_out0), .sbox_out1(sbox_out1), .abort(abort), .busy(busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [3:0] sbox_f(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
         4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
         4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
         4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] present_sl(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox_f(x[4*i +: 4]);
      return r;
   endfunction

   // one-cycle masked S-box: remasks the output with both random nibbles
   always_ff @(posedge clk) begin
      sbox_out0 <= sbox_f(sbox_in0 ^ sbox_in1) ^ sbox_ran[3:0] ^ sbox_ran[7:4];
      sbox_out1 <= sbox_ran[3:0] ^ sbox_ran[7:4];
   end

   always_ff @(posedge clk) if (rnd_valid && rnd_ready) rnd_used <= rnd_used + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic run_op(input logic [63:0] a0, input logic [63:0] a1, input bit stall,
                         input int bp, input int abort_at,
                         output int lat, output int used, output logic [63:0] res);
      int base, st1, st2;
      logic ok;
      logic [63:0] h0, h1;
      base = rnd_used;
      st1 = stall ? 3 : 0;
      st2 = stall ? 2 : 0;
      lat = 0;
      used = 0;
      res = '0;
      @(negedge clk);
      in_sh0 = a0;
      in_sh1 = a1;
      in_valid = 1;
      for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
      sb.push_back(present_sl(a0 ^ a1));
      @(negedge clk);
      in_valid = 0;
      while (!out_valid && lat < 200) begin
         used = rnd_used - base;
         if (abort_at >= 0 && used == abort_at) begin
            abort = 1;
            #1 chk("abort_rnd_ready", 64'(rnd_ready), 0);
            @(negedge clk);
            abort = 0;
            chk("abort_busy", 64'(busy), 0);
            void'(sb.pop_back());
            return;
         end
         rnd = 8'($urandom);
         rnd_valid = !((used == 6 && st1 > 0) || (used == 16 && st2 > 0));
         if (!rnd_valid) begin
            if (used == 6) st1--;
            else st2--;
         end
         @(negedge clk);
         lat++;
      end
      used = rnd_used - base;
      chk("out_valid_timeout", 64'(out_valid), 1);
      h0 = out_sh0;
      h1 = out_sh1;
      ok = 1;
      repeat (bp) begin
         @(negedge clk);
         if (out_sh0 !== h0 || out_sh1 !== h1 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 0;
      end
      if (bp > 0) chk("bp_stable", 64'(ok), 1);
      out_ready = 1;
      res = out_sh0 ^ out_sh1;
      if (sb.size() > 0) chk("result", res, sb.pop_front());
      else chk("sb_size", 64'(sb.size()), 1);
      @(negedge clk);
      out_ready = 0;
      chk("in_ready_after", 64'(in_ready), 1);
      chk("out_valid_after", 64'(out_valid), 0);
`ifdef SBOX_SEQ_ZEROIZE_EN
      chk("zero_sh0", out_sh0, 0);
      chk("zero_sh1", out_sh1, 0);
`else
      chk("keep_sh0", out_sh0, h0);
      chk("keep_sh1", out_sh1, h1);
`endif
   endtask

   initial begin
      int lat, used;
      logic [63:0] res, m;
      rst_n = 0; in_valid = 0; out_ready = 0; rnd_valid = 1; abort = 0;
      in_sh0 = '0; in_sh1 = '0; rnd = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_rnd_ready", 64'(rnd_ready), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_out_sh", out_sh0 | out_sh1, 0);
      chk("rst_sbox_in", 64'({sbox_in0, sbox_in1}), 0);
      rst_n = 1;
      run_op(64'hFEDCBA9876543210, 64'h0, 0, 0, -1, lat, used, res);
      chk("kat_value", res, 64'h21748FE3DA09B65C);
      chk("kat_latency", 64'(lat), 18);
      chk("kat_rnd_words", 64'(used), 16);
      for (int k = 0; k < 3; k++) begin
         m = {$urandom, $urandom};
         run_op(m ^ 64'hFEDCBA9876543210, m, 0, 0, -1, lat, used, res);
         chk("rand_value", res, 64'h21748FE3DA09B65C);
      end
      m = {$urandom, $urandom};
      run_op(m ^ 64'hFEDCBA9876543210, m, 1, 0, -1, lat, used, res);
      chk("stall_value", res, 64'h21748FE3DA09B65C);
      chk("stall_latency", 64'(lat), 21);
      chk("stall_rnd_words", 64'(used), 16);
      m = {$urandom, $urandom};
      run_op({$urandom, $urandom}, m, 0, 10, -1, lat, used, res);
      m = {$urandom, $urandom};
      run_op(m ^ 64'h0123456789ABCDEF, m, 0, 0, 9, lat, used, res);
      m = {$urandom, $urandom};
      run_op(m, m, 0, 0, -1, lat, used, res);
      chk("post_abort_value", res, 64'hCCCCCCCCCCCCCCCC);
      chk("post_abort_latency", 64'(lat), 18);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
